// File: rtl/sc_load_sequencer.sv
// MAROC slow-control load sequencer: latches a frame, resets the chip, then drives
// a load pass and a readback-verify pass through the serializer, retrying on failure.
module sc_load_sequencer #(
    parameter int unsigned FRAME_LEN  = 829,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned RST_CYCLES = 8,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                 CK_in,
    input  logic                 rst,
    input  logic                 cfg_req,
    input  logic [FRAME_LEN-1:0] cfg_frame,
    output logic                 cfg_ack,
    output logic [FRAME_LEN-1:0] tx_frame,
    output logic                 tx_start,
    input  logic                 tx_busy,
    input  logic                 bit_strobe,
    input  logic                 q_sc,
    output logic                 rstn_sc,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           retry_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);
    localparam logic [1:0]       MAX_RETRY_C = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, CHIP_RST, LOAD_START, LOAD_WAIT, VERIFY_START, VERIFY_WAIT, FAIL, DONE
    } state_t;

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] bit_cnt;
    logic             seen_busy;

    logic [CNT_W-1:0] bit_cnt_nx;
    logic [CNT_W-1:0] mism_nx;
    logic             bit_miss;
    logic             pass_end;

    // Bit counter saturates so an overlong pass can never wrap back to a valid count.
    always_comb begin
        bit_cnt_nx = bit_cnt;
        mism_nx    = mismatch_cnt;
        bit_miss   = 1'b0;
        if (bit_strobe) begin
            if (bit_cnt != '1)
                bit_cnt_nx = bit_cnt + 1'b1;
            if (bit_cnt < FRAME_LEN_C)
                bit_miss = q_sc ^ tx_frame[bit_cnt];
            if (bit_miss && (mismatch_cnt != '1))
                mism_nx = mismatch_cnt + 1'b1;
        end
    end

    assign pass_end = seen_busy && !tx_busy;

    always_ff @(posedge CK_in) begin
        if (rst) begin
            state        <= IDLE;
            cfg_ack      <= 1'b0;
            tx_start     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            rstn_sc      <= 1'b1;
            tx_frame     <= '0;
            retry_cnt    <= '0;
            mismatch_cnt <= '0;
            rst_cnt      <= '0;
            timer        <= '0;
            bit_cnt      <= '0;
            seen_busy    <= 1'b0;
        end else begin
            cfg_ack  <= 1'b0;
            tx_start <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_req) begin
                        cfg_ack      <= 1'b1;
                        tx_frame     <= cfg_frame;
                        retry_cnt    <= '0;
                        mismatch_cnt <= '0;
                        busy         <= 1'b1;
                        rstn_sc      <= 1'b0;
                        rst_cnt      <= '0;
                        state        <= CHIP_RST;
                    end
                end
                CHIP_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        rstn_sc <= 1'b1;
                        state   <= LOAD_START;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                LOAD_START, VERIFY_START: begin
                    tx_start  <= 1'b1;
                    bit_cnt   <= '0;
                    timer     <= '0;
                    seen_busy <= 1'b0;
                    if (state == VERIFY_START) begin
                        mismatch_cnt <= '0;
                        state        <= VERIFY_WAIT;
                    end else begin
                        state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT, VERIFY_WAIT: begin
                    timer   <= timer + 1'b1;
                    bit_cnt <= bit_cnt_nx;
                    if (tx_busy)
                        seen_busy <= 1'b1;
                    if (state == VERIFY_WAIT)
                        mismatch_cnt <= mism_nx;
                    if (pass_end) begin
                        if (state == LOAD_WAIT)
                            state <= (bit_cnt_nx == FRAME_LEN_C) ? VERIFY_START : FAIL;
                        else
                            state <= ((bit_cnt_nx == FRAME_LEN_C) && (mism_nx == '0)) ? DONE : FAIL;
                    end else if (timer == TMR_LAST) begin
                        state <= FAIL;
                    end
                end
                FAIL: begin
                    // Retries skip the chip reset and go straight back to loading.
                    if (retry_cnt < MAX_RETRY_C) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= LOAD_START;
                    end else begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_load_sequencer.sv
// Directed bench for sc_load_sequencer with a behavioural slow-control serializer model.
module tb_sc_load_sequencer;

    localparam int unsigned FL = 829;
    localparam int unsigned TO = 4096;

    logic          CK_in;
    logic          rst;
    logic          cfg_req;
    logic [FL-1:0] cfg_frame;
    logic          cfg_ack;
    logic [FL-1:0] tx_frame;
    logic          tx_start;
    logic          tx_busy;
    logic          bit_strobe;
    logic          q_sc;
    logic          rstn_sc;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    retry_cnt;
    logic [9:0]    mismatch_cnt;

    sc_load_sequencer #(
        .FRAME_LEN(FL), .CNT_W(10), .RST_CYCLES(8), .MAX_RETRY(3), .TIMEOUT(TO)
    ) dut (
        .CK_in(CK_in), .rst(rst), .cfg_req(cfg_req), .cfg_frame(cfg_frame),
        .cfg_ack(cfg_ack), .tx_frame(tx_frame), .tx_start(tx_start),
        .tx_busy(tx_busy), .bit_strobe(bit_strobe), .q_sc(q_sc),
        .rstn_sc(rstn_sc), .busy(busy), .done(done), .error(error),
        .retry_cnt(retry_cnt), .mismatch_cnt(mismatch_cnt)
    );

    initial begin
        CK_in = 1'b0;
        forever #5 CK_in = ~CK_in;
    end

    int unsigned asserts = 0;
    int unsigned fails   = 0;

    // Serializer model controls
    int unsigned   load_len   = FL;
    int unsigned   verify_len = FL;
    bit            never_busy = 1'b0;
    bit            stuck0     = 1'b0;
    int            flip_bit   = -1;
    int unsigned   verify_passes = 0;
    bit            next_is_verify = 1'b0;
    logic [FL-1:0] cur_frame = '0;
    bit            ser_in_verify = 1'b0;
    int unsigned   ser_bit = 0;
    bit            ser_v;
    int unsigned   ser_n;

    initial begin
        tx_busy = 1'b0; bit_strobe = 1'b0; q_sc = 1'b0;
        forever begin
            @(posedge CK_in); #1;
            if (tx_start === 1'b1 && !never_busy && rst !== 1'b1) begin
                ser_v = next_is_verify;
                ser_n = ser_v ? verify_len : load_len;
                if (ser_v) verify_passes++;
                ser_in_verify = ser_v;
                tx_busy = 1'b1;
                for (int unsigned i = 0; i < ser_n; i++) begin
                    if (rst === 1'b1) break;
                    ser_bit    = i;
                    bit_strobe = 1'b1;
                    if (!ser_v || stuck0)
                        q_sc = 1'b0;
                    else
                        q_sc = cur_frame[i] ^ ((verify_passes == 1) && (int'(i) == flip_bit));
                    @(posedge CK_in); #1;
                end
                bit_strobe = 1'b0; tx_busy = 1'b0; q_sc = 1'b0; ser_in_verify = 1'b0;
                next_is_verify = ser_v ? 1'b0 : (ser_n == FL);
            end
        end
    end

    // Event monitor, sampled on the falling edge
    int unsigned cyc = 0;
    int unsigned n_ack, n_start, n_done, n_err, n_both, n_rstn_low, max_mism;
    int unsigned ack_cyc, first_start_cyc, done_cyc, err_cyc;

    initial begin
        forever begin
            @(negedge CK_in);
            cyc++;
            if (cfg_ack === 1'b1) begin n_ack++; ack_cyc = cyc; end
            if (tx_start === 1'b1) begin n_start++; if (n_start == 1) first_start_cyc = cyc; end
            if (done === 1'b1) begin n_done++; done_cyc = cyc; end
            if (error === 1'b1) begin n_err++; err_cyc = cyc; end
            if (done === 1'b1 && error === 1'b1) n_both++;
            if (rstn_sc === 1'b0) n_rstn_low++;
            if (!$isunknown(mismatch_cnt) && int'(mismatch_cnt) > max_mism) max_mism = mismatch_cnt;
        end
    end

    task automatic clear_mon();
        n_ack = 0; n_start = 0; n_done = 0; n_err = 0; n_both = 0;
        n_rstn_low = 0; max_mism = 0;
        ack_cyc = 0; first_start_cyc = 0; done_cyc = 0; err_cyc = 0;
    endtask

    task automatic run_seq(input logic [FL-1:0] f, input int unsigned budget,
                           output bit got_ack, output bit got_end);
        cur_frame = f; next_is_verify = 1'b0; verify_passes = 0;
        clear_mon();
        cfg_frame = f; cfg_req = 1'b1;
        got_ack = 1'b0; got_end = 1'b0;
        for (int unsigned i = 0; i < 20 && !got_ack; i++) begin
            @(negedge CK_in); got_ack = (cfg_ack === 1'b1);
        end
        @(posedge CK_in); #1;
        cfg_req = 1'b0; cfg_frame = ~f;
        for (int unsigned i = 0; i < budget && !got_end; i++) begin
            @(negedge CK_in); got_end = (done === 1'b1) || (error === 1'b1);
        end
        repeat (3) @(posedge CK_in); #1;
    endtask

    task automatic make_rand_frame(output logic [FL-1:0] f);
        logic [31:0] w;
        w = '0;
        for (int unsigned i = 0; i < FL; i++) begin
            if (i % 32 == 0) w = $urandom;
            f[i] = w[i % 32];
        end
    endtask

    logic [FL-1:0] nom_frame;

    task automatic test_reset();
        rst = 1'b1; cfg_req = 1'b0; cfg_frame = '0;
        repeat (3) @(posedge CK_in);
        @(negedge CK_in);
        asserts++; if ({cfg_ack, tx_start, busy, done, error} !== 5'b0) begin fails++;
            $display("FAIL reset_pulses: got %b expected 00000", {cfg_ack, tx_start, busy, done, error}); end
        asserts++; if (rstn_sc !== 1'b1) begin fails++; $display("FAIL reset_rstn: got %b expected 1", rstn_sc); end
        asserts++; if (tx_frame !== '0) begin fails++; $display("FAIL reset_tx_frame: got nonzero expected 0"); end
        asserts++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
        asserts++; if (mismatch_cnt !== 10'd0) begin fails++; $display("FAIL reset_mismatch: got %0d expected 0", mismatch_cnt); end
        @(posedge CK_in); #1; rst = 1'b0;
        repeat (2) @(posedge CK_in); #1;
    endtask

    task automatic test_nominal();
        bit a, e;
        run_seq(nom_frame, 4000, a, e);
        asserts++; if (!a || !e) begin fails++; $display("FAIL nom_handshake: ack=%0d end=%0d expected 1 1", a, e); end
        asserts++; if (n_ack != 1) begin fails++; $display("FAIL nom_ack_count: got %0d expected 1", n_ack); end
        asserts++; if (n_rstn_low != 8) begin fails++; $display("FAIL nom_rstn_low: got %0d expected 8", n_rstn_low); end
        asserts++; if (n_start != 2) begin fails++; $display("FAIL nom_tx_start: got %0d expected 2", n_start); end
        asserts++; if (first_start_cyc - ack_cyc != 9) begin fails++;
            $display("FAIL nom_start_latency: got %0d expected 9", first_start_cyc - ack_cyc); end
        asserts++; if (n_done != 1 || n_err != 0) begin fails++; $display("FAIL nom_done: done=%0d err=%0d expected 1 0", n_done, n_err); end
        asserts++; if (mismatch_cnt !== 10'd0) begin fails++; $display("FAIL nom_mismatch: got %0d expected 0", mismatch_cnt); end
        asserts++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL nom_retry: got %0d expected 0", retry_cnt); end
        asserts++; if (tx_frame !== nom_frame) begin fails++; $display("FAIL nom_tx_frame: latched frame differs from acked frame"); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL nom_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_single_bit();
        bit a, e;
        flip_bit = 400;
        run_seq(nom_frame, 6000, a, e);
        flip_bit = -1;
        asserts++; if (!e) begin fails++; $display("FAIL sb_end: got timeout expected done"); end
        asserts++; if (n_done != 1 || n_err != 0) begin fails++; $display("FAIL sb_done: done=%0d err=%0d expected 1 0", n_done, n_err); end
        asserts++; if (retry_cnt !== 2'd1) begin fails++; $display("FAIL sb_retry: got %0d expected 1", retry_cnt); end
        asserts++; if (mismatch_cnt !== 10'd0) begin fails++; $display("FAIL sb_mismatch_final: got %0d expected 0", mismatch_cnt); end
        asserts++; if (max_mism != 1) begin fails++; $display("FAIL sb_mismatch_failpass: got %0d expected 1", max_mism); end
        asserts++; if (n_start != 4) begin fails++; $display("FAIL sb_tx_start: got %0d expected 4", n_start); end
    endtask

    task automatic test_persistent();
        bit a, e;
        logic [FL-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < 412; i++) f[i] = 1'b1;
        stuck0 = 1'b1;
        run_seq(f, 12000, a, e);
        stuck0 = 1'b0;
        asserts++; if (n_err != 1 || n_done != 0) begin fails++; $display("FAIL pe_error: err=%0d done=%0d expected 1 0", n_err, n_done); end
        asserts++; if (retry_cnt !== 2'd3) begin fails++; $display("FAIL pe_retry: got %0d expected 3", retry_cnt); end
        asserts++; if (mismatch_cnt !== 10'd412) begin fails++; $display("FAIL pe_mismatch: got %0d expected 412", mismatch_cnt); end
        asserts++; if (n_start != 8) begin fails++; $display("FAIL pe_tx_start: got %0d expected 8", n_start); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL pe_busy: got %b expected 0", busy); end
    endtask

    task automatic test_short_frame();
        bit a, e;
        load_len = FL - 1;
        run_seq(nom_frame, 8000, a, e);
        load_len = FL;
        asserts++; if (n_err != 1 || n_done != 0) begin fails++; $display("FAIL sf_error: err=%0d done=%0d expected 1 0", n_err, n_done); end
        asserts++; if (n_start != 4) begin fails++; $display("FAIL sf_tx_start: got %0d expected 4", n_start); end
        asserts++; if (retry_cnt !== 2'd3) begin fails++; $display("FAIL sf_retry: got %0d expected 3", retry_cnt); end
        asserts++; if (mismatch_cnt !== 10'd0) begin fails++; $display("FAIL sf_mismatch: got %0d expected 0", mismatch_cnt); end
    endtask

    task automatic test_timeout();
        bit a, e;
        never_busy = 1'b1;
        run_seq(nom_frame, 4 * TO + 200, a, e);
        never_busy = 1'b0;
        asserts++; if (n_err != 1 || n_done != 0) begin fails++; $display("FAIL to_error: err=%0d done=%0d expected 1 0", n_err, n_done); end
        asserts++; if (err_cyc - ack_cyc < 4 * TO || err_cyc - ack_cyc > 4 * TO + 40) begin fails++;
            $display("FAIL to_latency: got %0d expected %0d..%0d", err_cyc - ack_cyc, 4 * TO, 4 * TO + 40); end
        asserts++; if (n_start != 4) begin fails++; $display("FAIL to_tx_start: got %0d expected 4", n_start); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_verify();
        bit hit, a, e;
        cur_frame = nom_frame; next_is_verify = 1'b0; verify_passes = 0;
        clear_mon();
        cfg_frame = nom_frame; cfg_req = 1'b1;
        @(posedge CK_in); #1;
        @(posedge CK_in); #1;
        cfg_req = 1'b0;
        hit = 1'b0;
        for (int unsigned i = 0; i < 3000 && !hit; i++) begin
            @(negedge CK_in);
            hit = ser_in_verify && (ser_bit == 300);
        end
        asserts++; if (!hit) begin fails++; $display("FAIL rmv_reach_strobe300: got no verify strobe 300 expected one"); end
        rst = 1'b1;
        @(negedge CK_in);
        asserts++; if ({cfg_ack, tx_start, busy, done, error, rstn_sc} !== 6'b000001) begin fails++;
            $display("FAIL rmv_outputs: got %b expected 000001", {cfg_ack, tx_start, busy, done, error, rstn_sc}); end
        asserts++; if (tx_frame !== '0 || retry_cnt !== 2'd0 || mismatch_cnt !== 10'd0) begin fails++;
            $display("FAIL rmv_regs: retry=%0d mismatch=%0d expected 0 0 and frame 0", retry_cnt, mismatch_cnt); end
        @(posedge CK_in); #1; rst = 1'b0;
        repeat (3) @(posedge CK_in); #1;
        asserts++; if (n_done != 0 || n_err != 0) begin fails++; $display("FAIL rmv_no_pulse: done=%0d err=%0d expected 0 0", n_done, n_err); end
        run_seq(nom_frame, 4000, a, e);
        asserts++; if (n_ack != 1 || n_done != 1 || retry_cnt !== 2'd0) begin fails++;
            $display("FAIL rmv_restart: ack=%0d done=%0d retry=%0d expected 1 1 0", n_ack, n_done, retry_cnt); end
    endtask

    task automatic test_back_to_back();
        bit got;
        cur_frame = nom_frame; next_is_verify = 1'b0; verify_passes = 0;
        clear_mon();
        cfg_frame = nom_frame; cfg_req = 1'b1;
        got = 1'b0;
        for (int unsigned i = 0; i < 4000 && !got; i++) begin
            @(negedge CK_in); got = (done === 1'b1);
        end
        repeat (4) @(posedge CK_in); #1;
        asserts++; if (n_ack != 2) begin fails++; $display("FAIL b2b_ack_count: got %0d expected 2", n_ack); end
        asserts++; if (ack_cyc - done_cyc != 1) begin fails++; $display("FAIL b2b_ack_gap: got %0d expected 1", ack_cyc - done_cyc); end
        cfg_req = 1'b0;
        next_is_verify = 1'b0;
        got = 1'b0;
        for (int unsigned i = 0; i < 4000 && !got; i++) begin
            @(negedge CK_in); got = (done === 1'b1) || (error === 1'b1);
        end
        repeat (3) @(posedge CK_in); #1;
        asserts++; if (n_done != 2 || n_err != 0 || n_ack != 2) begin fails++;
            $display("FAIL b2b_second: done=%0d err=%0d ack=%0d expected 2 0 2", n_done, n_err, n_ack); end
        asserts++; if (n_both != 0) begin fails++; $display("FAIL done_error_overlap: got %0d expected 0", n_both); end
    endtask

    int unsigned seed_dummy;

    initial begin
        seed_dummy = $urandom(10);
        make_rand_frame(nom_frame);
        clear_mon();
        test_reset();
        test_nominal();
        test_single_bit();
        test_persistent();
        test_short_frame();
        test_timeout();
        test_reset_mid_verify();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
